// File: rtl/seq_share_pkg.sv
// seq_share_pkg: shared types, sequence codes and successor function for the
// two-requester sequence sharing controller (seq_share_ctrl).
//   state_t     : controller FSM states
//   SEQ_W       : width of a sequence context
//   SEQ_C0..C5  : the six codes of the cycle 0,8,5,3,7,2
//   seq_next()  : successor of a code; unknown codes fall back to 0
package seq_share_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int unsigned SEQ_W = 4;

  localparam logic [SEQ_W-1:0] SEQ_C0 = 4'd0;
  localparam logic [SEQ_W-1:0] SEQ_C1 = 4'd8;
  localparam logic [SEQ_W-1:0] SEQ_C2 = 4'd5;
  localparam logic [SEQ_W-1:0] SEQ_C3 = 4'd3;
  localparam logic [SEQ_W-1:0] SEQ_C4 = 4'd7;
  localparam logic [SEQ_W-1:0] SEQ_C5 = 4'd2;

  function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] cur);
    logic [SEQ_W-1:0] nxt;
    case (cur)
      SEQ_C0:  nxt = SEQ_C1;
      SEQ_C1:  nxt = SEQ_C2;
      SEQ_C2:  nxt = SEQ_C3;
      SEQ_C3:  nxt = SEQ_C4;
      SEQ_C4:  nxt = SEQ_C5;
      SEQ_C5:  nxt = SEQ_C0;
      default: nxt = SEQ_C0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_share_ctrl_ctx.sv
// seq_tff_ctx: one saved sequence context built from T flip-flops.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset, context -> 0
//   step    : advance the context one position in the cycle
//   restart : force the context to 0 (takes priority over step)
//   value   : current context value
module seq_tff_ctx
  import seq_share_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             step,
  input  logic             restart,
  output logic [SEQ_W-1:0] value
);

  // Toggle vector turns the current code into its successor.
  logic [SEQ_W-1:0] toggle;

  always_comb begin
    toggle = value ^ seq_next(value);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (restart) begin
      value <= '0;
    end else if (step) begin
      value <= value ^ toggle;
    end
  end

endmodule

// File: rtl/seq_share_ctrl.sv
// seq_share_ctrl: round-robin scheduler sharing one sequence engine between
// two requesters, each with its own saved context. A grant lasts up to
// BURST_LEN accepted steps or until the requester drops req; at least one
// idle cycle separates grants.
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   req        : per-requester level request
//   take       : per-requester accept (only the granted bit is honoured)
//   restart    : per-requester pulse, clears that context
//   gnt        : one-hot registered grant
//   gnt_id     : index of granted requester, holds when idle
//   seq_valid  : high while a requester is granted
//   seq_out    : granted requester's context, 0 when idle
//   wrap_count : 2->0 step counter (only with SEQ_WRAP_COUNT_EN defined)
module seq_share_ctrl
  import seq_share_pkg::*;
#(
  parameter int unsigned BURST_LEN = 6,
  parameter int unsigned NREQ      = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  take,
  input  logic [NREQ-1:0]  restart,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_id,
  output logic             seq_valid,
`ifdef SEQ_WRAP_COUNT_EN
  output logic [7:0]       wrap_count,
`endif
  output logic [SEQ_W-1:0] seq_out
);

  state_t           state;
  logic             last;
  logic [3:0]       beat;
  logic [SEQ_W-1:0] ctx [NREQ];
  logic [NREQ-1:0]  step_raw;
  logic             counted;
  logic             release_now;
  logic             pick;
  logic [SEQ_W-1:0] cur;

  // gnt is only non-zero in RUN, so it doubles as the step qualifier.
  always_comb begin
    step_raw    = gnt & take;
    counted     = |(step_raw & ~restart);
    cur         = ctx[gnt_id];
    release_now = (counted && (beat == 4'(BURST_LEN - 1))) || !req[gnt_id];
    pick        = (req == 2'b11) ? ~last : req[1];
    seq_out     = seq_valid ? cur : '0;
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_ctx
    seq_tff_ctx u_ctx (
      .clock   (clock),
      .reset_n (reset_n),
      .step    (step_raw[i]),
      .restart (restart[i]),
      .value   (ctx[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= 1'b0;
      seq_valid <= 1'b0;
      last      <= 1'b1;
      beat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            state     <= RUN;
            gnt       <= '0;
            gnt[pick] <= 1'b1;
            gnt_id    <= pick;
            seq_valid <= 1'b1;
            beat      <= '0;
          end
        end
        RUN: begin
          if (counted) begin
            beat <= beat + 4'd1;
          end
          if (release_now) begin
            state     <= IDLE;
            gnt       <= '0;
            seq_valid <= 1'b0;
            last      <= gnt_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_WRAP_COUNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap_count <= '0;
    end else if (counted && (cur == SEQ_C5)) begin
      wrap_count <= wrap_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_share_ctrl.sv
module tb_seq_share_ctrl;
  localparam int unsigned BURST_LEN = 6;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req = '0, take = '0, restart = '0;
  logic [1:0] gnt;
  logic       gnt_id, seq_valid;
  logic [3:0] seq_out;
`ifdef SEQ_WRAP_COUNT_EN
  logic [7:0] wrap_count;
`endif

  seq_share_ctrl #(.BURST_LEN(BURST_LEN), .NREQ(2)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .take(take), .restart(restart),
    .gnt(gnt), .gnt_id(gnt_id), .seq_valid(seq_valid),
`ifdef SEQ_WRAP_COUNT_EN
    .wrap_count(wrap_count),
`endif
    .seq_out(seq_out));

  always #5 clock = ~clock;

  // Reference model: contexts as positions within the cycle.
  int seq_tab [6] = '{0, 8, 5, 3, 7, 2};
  int pos [2];
  int granted;   // -1 when idle
  int gid, last_srv, beats, wraps;

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos[0] = 0; pos[1] = 0;
    granted = -1; gid = 0; last_srv = 1; beats = 0; wraps = 0;
  endtask

  task automatic check_outputs();
    check("gnt", 32'(gnt), (granted < 0) ? 0 : (1 << granted));
    check("gnt_id", 32'(gnt_id), 32'(gid));
    check("seq_valid", 32'(seq_valid), (granted < 0) ? 0 : 1);
    check("seq_out", 32'(seq_out), (granted < 0) ? 0 : 32'(seq_tab[pos[granted]]));
`ifdef SEQ_WRAP_COUNT_EN
    check("wrap_count", 32'(wrap_count), 32'(wraps % 256));
`endif
  endtask

  // Check current outputs, apply new inputs, advance model by one clock.
  task automatic cyc(input logic [1:0] r, input logic [1:0] t, input logic [1:0] rs);
    @(negedge clock);
    check_outputs();
    req = r; take = t; restart = rs;
    if (granted < 0) begin
      if (r != 2'b00) begin
        granted = (r == 2'b11) ? 1 - last_srv : (r[1] ? 1 : 0);
        gid = granted;
        beats = 0;
      end
    end else begin
      bit counted, rel;
      counted = t[granted] && !rs[granted];
      if (counted) begin
        if (pos[granted] == 5) wraps++;
        pos[granted] = (pos[granted] + 1) % 6;
        beats++;
      end
      rel = (counted && beats == BURST_LEN) || !r[granted];
      if (rel) begin
        last_srv = granted;
        granted = -1;
      end
    end
    for (int i = 0; i < 2; i++) if (rs[i]) pos[i] = 0;
  endtask

  initial begin
    model_reset();
    #12 reset_n = 1'b1;

    // Single requester, continuous take: full burst then idle.
    for (int i = 0; i < 10; i++) cyc(2'b01, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);

    // Both requesting continuously: alternating grants.
    for (int i = 0; i < 30; i++) cyc(2'b11, 2'b11, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);

    // Two steps, drop req, regrant resumes from saved context.
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b01, 2'b00, 2'b00);

    // Restart coinciding with a step on the granted requester.
    cyc(2'b01, 2'b01, 2'b01);
    for (int i = 0; i < 8; i++) cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);

    // Long run on requester 0 to exercise several wraps.
    for (int i = 0; i < 24; i++) cyc(2'b01, 2'b01, 2'b00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] r, t, rs;
      r[0] = ($urandom_range(0, 3) != 0);
      r[1] = ($urandom_range(0, 3) != 0);
      t[0] = ($urandom_range(0, 4) < 3);
      t[1] = ($urandom_range(0, 4) < 3);
      rs[0] = ($urandom_range(0, 19) == 0);
      rs[1] = ($urandom_range(0, 19) == 0);
      cyc(r, t, rs);
    end

    // Asynchronous reset in the middle of a burst.
    cyc(2'b00, 2'b00, 2'b00);
    cyc(2'b00, 2'b00, 2'b01 | 2'b10);
    cyc(2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) cyc(2'b01, 2'b01, 2'b00);
    cyc(2'b01, 2'b00, 2'b00);
    @(negedge clock);
    check("pre_reset_seq_out", 32'(seq_out), 32'd7);
    #2 reset_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_valid", 32'(seq_valid), 32'd0);
    check("async_seq_out", 32'(seq_out), 32'd0);
    model_reset();
    req = '0; take = '0; restart = '0;
    @(negedge clock);
    reset_n = 1'b1;
    cyc(2'b01, 2'b00, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);
    cyc(2'b10, 2'b00, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);
    cyc(2'b00, 2'b00, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_share_ctrl.md
Name: seq_share_ctrl

Overview:
- Scheduler that shares one T-flip-flop sequence engine between two requesters.
- The engine steps through the fixed cycle 0,8,5,3,7,2 and then wraps to 0.
- Each requester owns a saved 4-bit sequence context. It gets bursts of up to BURST_LEN steps under round-robin arbitration.
- Sits between the sequence datapath and its two consumer blocks.

Parameters:
- BURST_LEN, 6: maximum accepted steps per grant, legal range 1..15.
- NREQ, 2: number of requesters; fixed at 2, any other value is illegal.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  2  per-requester request, level; held while the requester wants values.
- take  input  2  per-requester accept; only the bit of the granted requester is honoured.
- restart  input  2  per-requester pulse; forces that requester's context to 0.
- gnt  output  2  one-hot grant, registered.
- gnt_id  output  1  index of the granted requester; holds its last value when idle.
- seq_valid  output  1  high while a requester is granted.
- seq_out  output  4  current sequence value of the granted requester's context; 0 when idle.
- wrap_count  output  8  present only with SEQ_WRAP_COUNT_EN.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; gnt=00, gnt_id=0, seq_valid=0, seq_out=0.
  - Both contexts=0; round-robin pointer favours requester 0; beat counter=0.
  - Release is synchronous to clock.
- Next-state map: 0->8, 8->5, 5->3, 3->7, 7->2, 2->0. Any other value ->0 (defensive).
- Context registers are T flip-flops: toggle vector = cur XOR next, applied only on a step.
- State IDLE:
  - If req!=00, pick a requester: if both are set, the non-last-served one wins; otherwise the single requester.
  - Next edge: state RUN, gnt one-hot, gnt_id=winner, beat counter=0.
  - Latency from req to gnt is 1 cycle.
- State RUN:
  - seq_valid=1; seq_out=ctx[gnt_id] combinationally from the context.
  - Step = take[gnt_id]. On step: ctx[gnt_id] advances one position and the beat counter increments.
  - take of the non-granted requester is ignored.
  - Release condition: (step and beat counter==BURST_LEN-1) or req[gnt_id]==0.
  - On release: next edge goes to IDLE; gnt=00, seq_valid=0; last-served=gnt_id.
  - If req drops in the same cycle as take=1, the step is performed, then release.
- At least one IDLE cycle separates consecutive grants, even to the other requester.
- Restart:
  - restart[i] clears ctx[i] to 0 on the next edge, granted or not.
  - If restart[i] and a step on i coincide, restart wins: ctx=0 and the beat is not counted.
  - Restart never affects grant state.
- The non-granted context never changes except by restart.
- Boundary cases:
  - BURST_LEN=1: exactly one step per grant.
  - Wrap 2->0 is an ordinary step.
  - Both req asserted continuously: grants alternate 0,1,0,1, each separated by one IDLE cycle.

Optional Feature:
- SEQ_WRAP_COUNT_EN defined:
  - Adds an 8-bit wrap_count output and register.
  - It increments on every step in which the stepped context goes 2->0, for either requester.
  - It wraps 255->0, resets to 0, and is not cleared by restart.
- SEQ_WRAP_COUNT_EN not defined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package seq_share_pkg:
  - State enum {IDLE, RUN}.
  - Localparams for the six sequence codes (0,8,5,3,7,2) and SEQ_W=4.
  - Function seq_next(4-bit) returning the successor.
- Sub-module seq_tff_ctx: one 4-bit T-flip-flop context with step, restart, clock and reset_n; outputs the current value.
  - Instantiated twice; the controller holds the FSM, arbiter and beat counter.

Test Plan:
- Reset then req=01 with take=1 continuously, BURST_LEN=6:
  - gnt=01 one cycle after req.
  - seq_out 0,8,5,3,7,2 on successive cycles, then gnt=00.
  - ctx0 is back at 0.
- req=11 continuously, take=11, BURST_LEN=6:
  - gnt sequence 01 (6 beats), IDLE, 10 (6 beats), IDLE, 01.
  - Each requester sees 0,8,5,3,7,2.
- req0 granted, 2 steps (ctx0=5), drop req0; then grant req0 again:
  - Resumes with seq_out=5.
  - ctx1 unchanged at 0 throughout.
- Granted req0 at ctx0=3, assert take0 and restart0 together:
  - ctx0=0 next cycle and the beat is not counted.
  - Burst still allows BURST_LEN further steps minus those already taken.
- Assert reset_n=0 mid-RUN at ctx0=7:
  - gnt=00, seq_valid=0, seq_out=0 immediately (asynchronous).
  - Both contexts 0 after release.
- With SEQ_WRAP_COUNT_EN: take=1 for 18 steps on requester 0 (BURST_LEN=6, req held) -> wrap_count=3.
